// File: rtl/can_reg_write_arbiter_if.sv
// Handshake and register-bank signals between the requesters, the write arbiter
// and the CAN register bank.
interface can_reg_write_arbiter_if #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8
);
    logic                host_req;
    logic [ADDR_W-1:0]   host_addr;
    logic [DATA_W-1:0]   host_wdata;
    logic                host_ack;
    logic                core_req;
    logic [ADDR_W-1:0]   core_addr;
    logic [DATA_W-1:0]   core_wdata;
    logic                core_ack;
    logic                clr_req;
    logic                clr_busy;
    logic [NUM_REGS-1:0] reg_we;
    logic [DATA_W-1:0]   reg_data;
    logic [NUM_REGS-1:0] reg_rst_sync;
    logic                addr_err;

    modport master (
        output host_req, host_addr, host_wdata, core_req, core_addr, core_wdata, clr_req,
        input  host_ack, core_ack, clr_busy, reg_we, reg_data, reg_rst_sync, addr_err
    );

    modport slave (
        input  host_req, host_addr, host_wdata, core_req, core_addr, core_wdata, clr_req,
        output host_ack, core_ack, clr_busy, reg_we, reg_data, reg_rst_sync, addr_err
    );
endinterface

// File: rtl/can_reg_write_arbiter.sv
// Shares the CAN register bank between host and core writers (round-robin on
// contention) and sequences a one-register-per-cycle bank clear.
module can_reg_write_arbiter #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    can_reg_write_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
    typedef enum logic {GRANT_HOST, GRANT_CORE} grant_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              state;
    grant_t              last_grant;
    logic [ADDR_W-1:0]   clr_idx;

    logic                grant_core;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic                win_valid;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] idx);
        return {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

    // NOTE: every signal assigned in always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant_core = 1'b0;
        win_addr   = bus.host_addr;
        win_data   = bus.host_wdata;
        // Core wins when alone, or on contention when the host had the last grant.
        if (bus.core_req && (!bus.host_req || last_grant == GRANT_HOST)) begin
            grant_core = 1'b1;
            win_addr   = bus.core_addr;
            win_data   = bus.core_wdata;
        end
        win_valid = 32'(win_addr) < NUM_REGS;
    end

    // NOTE: state and registered outputs use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            last_grant       <= GRANT_HOST;
            clr_idx          <= '0;
            bus.host_ack     <= 1'b0;
            bus.core_ack     <= 1'b0;
            bus.clr_busy     <= 1'b0;
            bus.reg_we       <= '0;
            bus.reg_data     <= '0;
            bus.reg_rst_sync <= '0;
            bus.addr_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        state            <= CLEAR;
                        clr_idx          <= '0;
                        bus.clr_busy     <= 1'b1;
                        bus.reg_rst_sync <= onehot('0);
                    end else if (bus.host_req || bus.core_req) begin
                        state        <= WRITE;
                        last_grant   <= grant_core ? GRANT_CORE : GRANT_HOST;
                        bus.reg_data <= win_data;
                        bus.reg_we   <= win_valid ? onehot(win_addr) : '0;
                        bus.addr_err <= !win_valid;
                        bus.host_ack <= !grant_core;
                        bus.core_ack <= grant_core;
                    end
                end
                WRITE: begin
                    // Single-cycle write; a clr_req seen here is intentionally dropped.
                    state        <= IDLE;
                    bus.reg_we   <= '0;
                    bus.addr_err <= 1'b0;
                    bus.host_ack <= 1'b0;
                    bus.core_ack <= 1'b0;
                end
                CLEAR: begin
                    if (clr_idx == LAST_IDX) begin
                        state            <= IDLE;
                        clr_idx          <= '0;
                        bus.clr_busy     <= 1'b0;
                        bus.reg_rst_sync <= '0;
                    end else begin
                        clr_idx          <= clr_idx + ADDR_W'(1);
                        bus.reg_rst_sync <= onehot(clr_idx + ADDR_W'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_can_reg_write_arbiter.sv
// Directed self-checking bench for can_reg_write_arbiter: a 32-register instance
// for arbitration/clear/reset, and a 20-register instance for address range.
module tb_can_reg_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    can_reg_write_arbiter_if #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(8)) bus32 ();
    can_reg_write_arbiter_if #(.NUM_REGS(20), .ADDR_W(5), .DATA_W(8)) bus20 ();

    can_reg_write_arbiter #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(8)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    can_reg_write_arbiter #(.NUM_REGS(20), .ADDR_W(5), .DATA_W(8)) dut20 (
        .clk (clk),
        .rst (rst),
        .bus (bus20)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
        end
    endtask

    // Outputs settle just after the active edge; stimulus changes there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet32(input string tag);
        check({tag, " host_ack"}, 32'(bus32.host_ack), 32'd0);
        check({tag, " core_ack"}, 32'(bus32.core_ack), 32'd0);
        check({tag, " clr_busy"}, 32'(bus32.clr_busy), 32'd0);
        check({tag, " reg_we"}, bus32.reg_we, 32'd0);
        check({tag, " reg_rst_sync"}, bus32.reg_rst_sync, 32'd0);
        check({tag, " addr_err"}, 32'(bus32.addr_err), 32'd0);
    endtask

    initial begin
        bus32.host_req = 1'b0; bus32.host_addr = '0; bus32.host_wdata = '0;
        bus32.core_req = 1'b0; bus32.core_addr = '0; bus32.core_wdata = '0;
        bus32.clr_req  = 1'b0;
        bus20.host_req = 1'b0; bus20.host_addr = '0; bus20.host_wdata = '0;
        bus20.core_req = 1'b0; bus20.core_addr = '0; bus20.core_wdata = '0;
        bus20.clr_req  = 1'b0;

        // Reset state
        tick();
        check_quiet32("reset");
        check("reset reg_data", 32'(bus32.reg_data), 32'd0);
        check("reset20 reg_we", 32'(bus20.reg_we), 32'd0);
        rst = 1'b0;
        tick();

        // Host-only write, addr 3, data 0xA5
        bus32.host_req = 1'b1; bus32.host_addr = 5'd3; bus32.host_wdata = 8'hA5;
        tick();
        check("host reg_we", bus32.reg_we, 32'h0000_0008);
        check("host reg_data", 32'(bus32.reg_data), 32'hA5);
        check("host host_ack", 32'(bus32.host_ack), 32'd1);
        check("host core_ack", 32'(bus32.core_ack), 32'd0);
        check("host addr_err", 32'(bus32.addr_err), 32'd0);
        bus32.host_req = 1'b0;
        tick();
        check_quiet32("host after");
        check("host data hold", 32'(bus32.reg_data), 32'hA5);

        // Simultaneous requests: last grant was host, so core goes first
        bus32.host_req = 1'b1; bus32.host_addr = 5'd1; bus32.host_wdata = 8'h11;
        bus32.core_req = 1'b1; bus32.core_addr = 5'd2; bus32.core_wdata = 8'h22;
        tick();
        check("contend1 reg_we", bus32.reg_we, 32'h0000_0004);
        check("contend1 reg_data", 32'(bus32.reg_data), 32'h22);
        check("contend1 core_ack", 32'(bus32.core_ack), 32'd1);
        check("contend1 host_ack", 32'(bus32.host_ack), 32'd0);
        bus32.core_req = 1'b0;
        tick();
        check_quiet32("contend gap");
        tick();
        check("contend2 reg_we", bus32.reg_we, 32'h0000_0002);
        check("contend2 reg_data", 32'(bus32.reg_data), 32'h11);
        check("contend2 host_ack", 32'(bus32.host_ack), 32'd1);
        check("contend2 core_ack", 32'(bus32.core_ack), 32'd0);
        bus32.host_req = 1'b0;
        tick();
        check_quiet32("contend after");

        // Both held for six writes: core, host, core, host, core, host
        bus32.host_req = 1'b1; bus32.host_addr = 5'd4; bus32.host_wdata = 8'h40;
        bus32.core_req = 1'b1; bus32.core_addr = 5'd5; bus32.core_wdata = 8'h50;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i % 2 == 0) begin
                check("alt core_ack", 32'(bus32.core_ack), 32'd1);
                check("alt host_ack", 32'(bus32.host_ack), 32'd0);
                check("alt reg_we core", bus32.reg_we, 32'h0000_0020);
                check("alt reg_data core", 32'(bus32.reg_data), 32'h50);
            end else begin
                check("alt host_ack", 32'(bus32.host_ack), 32'd1);
                check("alt core_ack", 32'(bus32.core_ack), 32'd0);
                check("alt reg_we host", bus32.reg_we, 32'h0000_0010);
                check("alt reg_data host", 32'(bus32.reg_data), 32'h40);
            end
            tick();
            check("alt gap acks", 32'({bus32.host_ack, bus32.core_ack}), 32'd0);
        end
        bus32.host_req = 1'b0; bus32.core_req = 1'b0;
        tick();
        check_quiet32("alt after");

        // Bank clear: 32-cycle walk, a restart pulse ignored, host held off until done
        bus32.clr_req = 1'b1;
        tick();
        bus32.clr_req = 1'b0;
        for (int k = 0; k < 32; k++) begin
            check("clr rst_sync", bus32.reg_rst_sync, 32'd1 << k);
            check("clr busy", 32'(bus32.clr_busy), 32'd1);
            check("clr reg_we", bus32.reg_we, 32'd0);
            check("clr host_ack", 32'(bus32.host_ack), 32'd0);
            if (k == 5) begin
                bus32.host_req = 1'b1; bus32.host_addr = 5'd7; bus32.host_wdata = 8'h77;
            end
            bus32.clr_req = (k == 8);
            tick();
        end
        bus32.clr_req = 1'b0;
        check("clr end busy", 32'(bus32.clr_busy), 32'd0);
        check("clr end rst_sync", bus32.reg_rst_sync, 32'd0);
        check("clr end host_ack", 32'(bus32.host_ack), 32'd0);
        tick();
        check("post clr host_ack", 32'(bus32.host_ack), 32'd1);
        check("post clr reg_we", bus32.reg_we, 32'h0000_0080);
        check("post clr reg_data", 32'(bus32.reg_data), 32'h77);
        bus32.host_req = 1'b0;
        tick();
        check_quiet32("post clr after");

        // Address range on the 20-register instance: last valid, then out of range
        bus20.core_req = 1'b1; bus20.core_addr = 5'd19; bus20.core_wdata = 8'h5A;
        tick();
        check("r20 edge reg_we", 32'(bus20.reg_we), 32'h0008_0000);
        check("r20 edge addr_err", 32'(bus20.addr_err), 32'd0);
        check("r20 edge core_ack", 32'(bus20.core_ack), 32'd1);
        bus20.core_req = 1'b0;
        tick();
        bus20.core_req = 1'b1; bus20.core_addr = 5'h1F; bus20.core_wdata = 8'h99;
        tick();
        check("r20 oor core_ack", 32'(bus20.core_ack), 32'd1);
        check("r20 oor addr_err", 32'(bus20.addr_err), 32'd1);
        check("r20 oor reg_we", 32'(bus20.reg_we), 32'd0);
        bus20.core_req = 1'b0;
        tick();
        check("r20 after addr_err", 32'(bus20.addr_err), 32'd0);
        check("r20 after core_ack", 32'(bus20.core_ack), 32'd0);

        // Async reset at cycle 10 of a clear
        bus32.clr_req = 1'b1;
        tick();
        bus32.clr_req = 1'b0;
        repeat (10) tick();
        check("mid clr rst_sync", bus32.reg_rst_sync, 32'h0000_0400);
        #2;
        rst = 1'b1;
        #1;
        check_quiet32("async rst");
        check("async rst reg_data", 32'(bus32.reg_data), 32'd0);
        tick();
        rst = 1'b0;
        bus32.host_req = 1'b1; bus32.host_addr = 5'd0; bus32.host_wdata = 8'h3C;
        tick();
        check("rst host reg_we", bus32.reg_we, 32'h0000_0001);
        check("rst host reg_data", 32'(bus32.reg_data), 32'h3C);
        check("rst host ack", 32'(bus32.host_ack), 32'd1);
        check("rst host busy", 32'(bus32.clr_busy), 32'd0);
        bus32.host_req = 1'b0;
        tick();
        check_quiet32("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/can_reg_write_arbiter.md
Name: can_reg_write_arbiter

Overview:
Write controller in front of a bank of NUM_REGS 8-bit CAN registers, each with async reset, sync clear and write enable. Shares the bank between two requesters: the host bus interface and the internal CAN core (status/error-counter updates). Also sequences a bank clear that walks every register's sync-clear input in turn. Sits between the register-decode logic and the register instances; produces their write-enable, data and sync-clear inputs.

Parameters:
NUM_REGS, 32, number of registers in the bank (2..2**ADDR_W)
ADDR_W, 5, register address width
DATA_W, 8, register data width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
host_req  in  1  host write request, level, held until host_ack
host_addr  in  ADDR_W  host target register
host_wdata  in  DATA_W  host write data
host_ack  out  1  one-cycle pulse, host write completed
core_req  in  1  core write request, level, held until core_ack
core_addr  in  ADDR_W  core target register
core_wdata  in  DATA_W  core write data
core_ack  out  1  one-cycle pulse, core write completed
clr_req  in  1  bank-clear start pulse
clr_busy  out  1  high while a clear sequence runs
reg_we  out  NUM_REGS  one-hot write enable to the register bank
reg_data  out  DATA_W  shared write data to the register bank
reg_rst_sync  out  NUM_REGS  one-hot sync clear to the register bank
addr_err  out  1  one-cycle pulse, granted write had address >= NUM_REGS

Behaviour:
- Reset (rst high, async): state IDLE; all outputs 0; clr_idx=0; last_grant=HOST, so the first contention after reset goes to the core.
- States: IDLE, WRITE, CLEAR. All outputs are registered.
- IDLE evaluation priority, highest first:
  - clr_req=1 → CLEAR with clr_idx=0. Write requests stay pending.
  - Both host_req and core_req high → grant the side that is not last_grant, then update last_grant.
  - One request high → grant it and update last_grant.
  - No request → stay in IDLE.
- On a grant, the winner's addr and wdata are latched and the FSM enters WRITE.
- WRITE lasts exactly one cycle:
  - reg_we[addr]=1 and reg_data=wdata.
  - The winner's ack is pulsed in the same cycle.
  - Back to IDLE.
- Write latency: request seen at edge N → reg_we/ack high during cycle N+1 → register updates at edge N+2. Peak throughput is one write every 2 cycles.
- Requester protocol: drop req in the cycle after ack. If req is still high in IDLE, it is treated as a new request.
- Address >= NUM_REGS: ack and addr_err pulse together, reg_we stays all-zero, no register changes.
- reg_data holds its last value when no write is active. Registers ignore it without we.
- CLEAR state:
  - Each cycle, reg_rst_sync[clr_idx]=1 (one-hot), clr_busy=1, then clr_idx increments.
  - After clr_idx=NUM_REGS-1, clr_idx returns to 0 and the FSM goes to IDLE.
  - Total duration is NUM_REGS cycles.
  - clr_req during CLEAR is ignored, with no restart and no queueing.
  - host_req and core_req are not acked during CLEAR. They are arbitrated in IDLE afterwards.
- clr_req arriving in the WRITE cycle is lost. The decode logic only issues clr_req while clr_busy=0 and no ack is outstanding.
- reg_we and reg_rst_sync are never both nonzero in the same cycle.
- Async reset mid-CLEAR or mid-WRITE: immediate return to the reset values. A partially walked clear is abandoned.
- clr_idx width is ADDR_W. Compare against NUM_REGS-1 for wrap; never rely on natural overflow.

Test Plan:
- Host only, addr=3, wdata=0xA5 → reg_we=0x00000008 and reg_data=0xA5 in cycle N+1, host_ack one pulse, core_ack=0.
- host_req and core_req rise together after reset (addr 1/2, data 0x11/0x22) → core granted first (reg_we bit2, 0x22), then host (bit1, 0x11) two cycles later; each ack pulses once.
- Both requests held continuously for 6 writes → grants alternate core, host, core, host, core, host; no requester gets two consecutive grants.
- clr_req pulse with NUM_REGS=32 → clr_busy high for exactly 32 cycles; reg_rst_sync walks 0x1, 0x2 … 0x80000000. A host_req raised at cycle 5 of the clear is acked only after clr_busy falls.
- Core write to addr=0x1F with NUM_REGS=20 → core_ack and addr_err pulse together, reg_we stays 0.
- rst asserted at cycle 10 of a clear → all outputs 0 the same cycle. After release, a host write to addr 0 completes normally with 2-cycle latency.
